dpram_be: RTL and testbench
===========================

Name: dpram_be

Overview:
- True dual-port synchronous RAM: two independent read/write ports (A, B) on one clock.
- Per-byte write enables and a selectable same-port read-during-write mode.
- Optional output pipeline register.
- Built-in post-reset clear sequencer that fills memory with a constant.
- Successor to the single-port RAM in core memory maps: shared video/CPU buffers, scratch RAM needing a known power-on state.

Parameters:
- data_width, 8, word width in bits; must be a multiple of 8.
- addr_width, 10, address bits; depth = 2**addr_width.
- rdw_mode, 0, same-port read-during-write: 0 = new data (write-first), 1 = old data (read-first).
- out_reg, 0, 1 adds a second output register stage (read latency 2).
- clear_on_reset, 1, 1 = run the clear sequence after every reset.
- init_value, 0, data_width-bit word written to every location by the clear sequence.

Ports:
- clock  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- cs_a  in  1  port A select; low = port A idle, q_a holds.
- wren_a  in  1  port A write enable, qualified by cs_a.
- byteena_a  in  data_width/8  port A byte enables; bit i covers data bits [8i+7:8i].
- address_a  in  addr_width  port A address.
- data_a  in  data_width  port A write data.
- q_a  out  data_width  port A read data.
- cs_b, wren_b, byteena_b, address_b, data_b, q_b: identical to port A, for port B.
- busy  out  1  high while the clear sequence runs; both user ports are ignored.

Behaviour:
- Reset (sampled at posedge):
  - q_a, q_b and both output-stage registers go to 0.
  - Clear counter goes to 0.
  - FSM goes to CLEAR if clear_on_reset=1, else IDLE.
  - busy follows the FSM state (1 in CLEAR) from the first cycle after reset.
  - Memory is not altered by reset itself.
- FSM states: IDLE, CLEAR.
  - CLEAR, each cycle: mem[clr_cnt] <= init_value, clr_cnt++.
  - When clr_cnt == 2**addr_width-1, that last location is written and the FSM moves to IDLE next cycle.
  - CLEAR lasts exactly 2**addr_width cycles.
  - Reset asserted mid-clear restarts the sequence at address 0.
- During CLEAR: all user writes are dropped; q_a and q_b hold 0.
- Read (IDLE, cs=1): stage-1 register <= mem[address] at the clock edge.
  - out_reg=0: q is stage 1, latency 1.
  - out_reg=1: stage 2 <= stage 1 every cycle, latency 2.
- cs=0: no memory access, stage 1 holds. wren with cs=0 has no effect.
- Write (IDLE, cs=1, wren=1): only bytes with byteena set are written. byteena all zero = no write; the cycle behaves as a read.
- Same-port read-during-write:
  - rdw_mode=0: stage 1 gets the merged word (enabled bytes from data, the rest from the old word).
  - rdw_mode=1: stage 1 gets the old word.
- Cross-port, same address:
  - A reads while B writes, or B reads while A writes: the reading port always gets the old word.
  - Both ports write: a byte enabled on both ports takes port A data; a byte enabled on one port only takes that port's data.
- Address wrap: none needed, addresses are full-range. The clear counter is addr_width+1 wide or compare-terminated; it must not wrap back into a second pass.

Decomposition:
- Package dpram_pkg:
  - State enum (IDLE, CLEAR).
  - Constants RDW_NEW_DATA=0, RDW_OLD_DATA=1.
  - Function computing byte-merge of old/new words under an enable mask.
- One sub-module, dpram_clear_seq: FSM, counter and busy output. It produces the clear write address/enable that override port A's write path.

Test Plan:
- Clear: addr_width=4, init_value=8'hA5, pulse reset.
  - busy high for exactly 16 cycles.
  - Port A writes during busy are dropped.
  - Afterwards, reading all 16 addresses returns 8'hA5.
- Byte enables: data_width=16. Write 16'h1234 to addr 3 with be=2'b11, then 16'hABCD with be=2'b10. Read addr 3 -> 16'hAB34.
- Same-port read-during-write: mem[5]=8'h11, write 8'h22 to addr 5.
  - rdw_mode=0: q_a=8'h22 next cycle.
  - rdw_mode=1: q_a=8'h11, then 8'h22 on the following read.
- Cross-port collision: data_width=16, A writes 16'hAAAA be=2'b01, B writes 16'hBBBB be=2'b11, both to addr 7 in the same cycle. Read -> 16'hBBAA.
  - Same cycle, B reading addr 7 while A writes: B returns the prior value.
- Latency/hold: out_reg=1, read addr 2 (holding 8'h5C). q_a=8'h5C exactly 2 cycles later. Then drop cs_a: q_a holds 8'h5C.
- Reset mid-clear: assert reset at clear cycle 9. busy stays high and the sequence restarts at 0, taking 16 more cycles after reset.

Source files
------------

// File: rtl/dpram_pkg.sv
// Shared types, constants and the byte-merge helper for the byte-enabled dual-port RAM.
package dpram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    localparam int RDW_NEW_DATA = 0;
    localparam int RDW_OLD_DATA = 1;

    // Widest word the merge helper handles; callers zero-extend and slice back down.
    localparam int MAX_DW = 256;
    localparam int MAX_BE = MAX_DW / 8;

    function automatic logic [MAX_DW-1:0] byte_merge(
        input logic [MAX_DW-1:0] old_word,
        input logic [MAX_DW-1:0] new_word,
        input logic [MAX_BE-1:0] be
    );
        logic [MAX_DW-1:0] result;
        result = old_word;
        for (int i = 0; i < MAX_BE; i++) begin
            if (be[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dpram_clear_seq.sv
// Post-reset clear sequencer: walks every address once, then hands the RAM to the user ports.
module dpram_clear_seq
    import dpram_pkg::*;
#(
    parameter int addr_width     = 10,
    parameter int clear_on_reset = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  busy,
    output logic                  clr_we,
    output logic [addr_width-1:0] clr_addr
);

    localparam logic [addr_width-1:0] LAST_ADDR = '1;

    clr_state_t            state_reg;
    logic [addr_width-1:0] cnt_reg;
    logic                  busy_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= (clear_on_reset != 0) ? CLEAR : IDLE;
            busy_reg  <= (clear_on_reset != 0);
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    busy_reg <= 1'b0;
                end
                CLEAR: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    // Compare-terminated: the counter's wrap to 0 coincides with leaving CLEAR.
                    if (cnt_reg == LAST_ADDR) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_reg;
    assign clr_we   = busy_reg && !reset;
    assign clr_addr = cnt_reg;

endmodule

// File: rtl/dpram_be.sv
// True dual-port RAM with byte enables, selectable read-during-write, optional output
// register and a built-in clear sequence that owns port A's write path while busy.
module dpram_be
    import dpram_pkg::*;
#(
    parameter int                    data_width     = 8,
    parameter int                    addr_width     = 10,
    parameter int                    rdw_mode       = 0,
    parameter int                    out_reg        = 0,
    parameter int                    clear_on_reset = 1,
    parameter logic [data_width-1:0] init_value     = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cs_a,
    input  logic                    wren_a,
    input  logic [data_width/8-1:0] byteena_a,
    input  logic [addr_width-1:0]   address_a,
    input  logic [data_width-1:0]   data_a,
    output logic [data_width-1:0]   q_a,
    input  logic                    cs_b,
    input  logic                    wren_b,
    input  logic [data_width/8-1:0] byteena_b,
    input  logic [addr_width-1:0]   address_b,
    input  logic [data_width-1:0]   data_b,
    output logic [data_width-1:0]   q_b,
    output logic                    busy
);

    localparam int NB    = data_width / 8;
    localparam int DEPTH = 2 ** addr_width;

    logic [data_width-1:0] mem [DEPTH];

    logic                  clr_we;
    logic [addr_width-1:0] clr_addr;

    dpram_clear_seq #(
        .addr_width     (addr_width),
        .clear_on_reset (clear_on_reset)
    ) u_clear_seq (
        .clock    (clock),
        .reset    (reset),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    logic                  user_ok;
    logic [1:0]            rd_p;
    logic [addr_width-1:0] addr_p    [2];
    logic [data_width-1:0] data_p    [2];
    logic [NB-1:0]         user_we_p [2];
    logic [data_width-1:0] q_p       [2];

    logic [NB-1:0]         we_a;
    logic [addr_width-1:0] wr_addr_a;
    logic [data_width-1:0] wr_data_a;

    always_comb begin
        user_ok      = !busy && !reset;
        addr_p[0]    = address_a;
        addr_p[1]    = address_b;
        data_p[0]    = data_a;
        data_p[1]    = data_b;
        rd_p[0]      = user_ok && cs_a;
        rd_p[1]      = user_ok && cs_b;
        user_we_p[0] = (user_ok && cs_a && wren_a) ? byteena_a : '0;
        user_we_p[1] = (user_ok && cs_b && wren_b) ? byteena_b : '0;
        we_a         = user_we_p[0];
        wr_addr_a    = address_a;
        wr_data_a    = data_a;
        if (clr_we) begin
            we_a      = '1;
            wr_addr_a = clr_addr;
            wr_data_a = init_value;
        end
    end

    // Port A is applied last so it wins any byte both ports enable at the same address.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NB; i++) begin
            if (user_we_p[1][i]) begin
                mem[address_b][8*i +: 8] <= data_b[8*i +: 8];
            end
            if (we_a[i]) begin
                mem[wr_addr_a][8*i +: 8] <= wr_data_a[8*i +: 8];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [MAX_DW-1:0]     merged_word;
            logic [data_width-1:0] stage1_reg;

            always_comb begin
                merged_word = byte_merge(MAX_DW'(mem[addr_p[gi]]), MAX_DW'(data_p[gi]),
                                         MAX_BE'(user_we_p[gi]));
            end

            // Cross-port reads see the pre-edge word; only the own port's write can merge in.
            always_ff @(posedge clock) begin
                if (reset) begin
                    stage1_reg <= '0;
                end else if (rd_p[gi]) begin
                    if (rdw_mode == RDW_NEW_DATA) begin
                        stage1_reg <= merged_word[data_width-1:0];
                    end else begin
                        stage1_reg <= mem[addr_p[gi]];
                    end
                end
            end

            if (out_reg != 0) begin : g_pipe
                logic [data_width-1:0] stage2_reg;

                always_ff @(posedge clock) begin
                    if (reset) begin
                        stage2_reg <= '0;
                    end else begin
                        stage2_reg <= stage1_reg;
                    end
                end

                assign q_p[gi] = stage2_reg;
            end else begin : g_nopipe
                assign q_p[gi] = stage1_reg;
            end
        end
    endgenerate

    assign q_a = q_p[0];
    assign q_b = q_p[1];

endmodule

// File: tb/tb_dpram_be.sv
// Directed bench for dpram_be: an 8-bit write-first instance and a 16-bit read-first,
// double-registered instance share clock and reset.
module tb_dpram_be;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic       cs_a0, wren_a0, cs_b0, wren_b0, busy0;
    logic [0:0] be_a0, be_b0;
    logic [3:0] addr_a0, addr_b0;
    logic [7:0] data_a0, data_b0, q_a0, q_b0;

    logic        cs_a1, wren_a1, cs_b1, wren_b1, busy1;
    logic [1:0]  be_a1, be_b1;
    logic [3:0]  addr_a1, addr_b1;
    logic [15:0] data_a1, data_b1, q_a1, q_b1;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clock = ~clock;

    dpram_be #(
        .data_width(8), .addr_width(4), .rdw_mode(0), .out_reg(0),
        .clear_on_reset(1), .init_value(8'hA5)
    ) u_dut0 (
        .clock(clock), .reset(reset),
        .cs_a(cs_a0), .wren_a(wren_a0), .byteena_a(be_a0), .address_a(addr_a0),
        .data_a(data_a0), .q_a(q_a0),
        .cs_b(cs_b0), .wren_b(wren_b0), .byteena_b(be_b0), .address_b(addr_b0),
        .data_b(data_b0), .q_b(q_b0),
        .busy(busy0)
    );

    dpram_be #(
        .data_width(16), .addr_width(4), .rdw_mode(1), .out_reg(1),
        .clear_on_reset(1), .init_value(16'h0000)
    ) u_dut1 (
        .clock(clock), .reset(reset),
        .cs_a(cs_a1), .wren_a(wren_a1), .byteena_a(be_a1), .address_a(addr_a1),
        .data_a(data_a1), .q_a(q_a1),
        .cs_b(cs_b1), .wren_b(wren_b1), .byteena_b(be_b1), .address_b(addr_b1),
        .data_b(data_b1), .q_b(q_b1),
        .busy(busy1)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-20s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cs_a0 = 0; wren_a0 = 0; be_a0 = 1'b0; addr_a0 = 0; data_a0 = 0;
        cs_b0 = 0; wren_b0 = 0; be_b0 = 1'b0; addr_b0 = 0; data_b0 = 0;
        cs_a1 = 0; wren_a1 = 0; be_a1 = 2'b00; addr_a1 = 0; data_a1 = 0;
        cs_b1 = 0; wren_b1 = 0; be_b1 = 2'b00; addr_b1 = 0; data_b1 = 0;

        // Reset state
        tick(); tick();
        check("reset_q_a0", {8'h00, q_a0}, 16'h0000);
        check("reset_q_b1", q_b1, 16'h0000);
        check("busy_in_reset", {15'b0, busy0}, 16'h0001);

        // Clear sequence with a port A write that must be dropped
        cs_a0 = 1; wren_a0 = 1; be_a0 = 1'b1; addr_a0 = 4'd0; data_a0 = 8'h3C;
        reset = 0;
        n = 0;
        while (busy0 && n < 40) begin
            n++;
            tick();
        end
        check("busy_cycles", 16'(n), 16'd16);
        check("busy1_done", {15'b0, busy1}, 16'h0000);
        wren_a0 = 0;
        for (int i = 0; i < 16; i++) begin
            addr_a0 = 4'(i);
            tick();
            check($sformatf("clear_rd_%0d", i), {8'h00, q_a0}, 16'h00A5);
        end

        // Write-first same-port RDW; port B reading the same address sees the old word
        wren_a0 = 1; addr_a0 = 4'd5; data_a0 = 8'h11;
        tick();
        check("rdw0_first", {8'h00, q_a0}, 16'h0011);
        data_a0 = 8'h22;
        cs_b0 = 1; addr_b0 = 4'd5;
        tick();
        check("rdw0_new", {8'h00, q_a0}, 16'h0022);
        check("rdw0_xport_old", {8'h00, q_b0}, 16'h0011);
        cs_b0 = 0; wren_a0 = 0;
        tick();
        check("rdw0_reread", {8'h00, q_a0}, 16'h0022);
        cs_a0 = 0;

        // Byte enables on the 16-bit instance (latency 2)
        cs_a1 = 1; wren_a1 = 1; addr_a1 = 4'd3; data_a1 = 16'h1234; be_a1 = 2'b11;
        tick();
        data_a1 = 16'hABCD; be_a1 = 2'b10;
        tick();
        wren_a1 = 0;
        tick(); tick();
        check("byteena_merge", q_a1, 16'hAB34);

        // Cross-port collision at address 7
        wren_a1 = 1; addr_a1 = 4'd7; data_a1 = 16'h1111; be_a1 = 2'b11;
        tick();
        data_a1 = 16'hAAAA; be_a1 = 2'b01;
        cs_b1 = 1; wren_b1 = 1; addr_b1 = 4'd7; data_b1 = 16'hBBBB; be_b1 = 2'b11;
        tick();
        data_a1 = 16'h5555; be_a1 = 2'b11;
        wren_b1 = 0;
        tick();
        cs_a1 = 0; wren_a1 = 0;
        tick();
        check("xport_collide", q_b1, 16'hBBAA);
        tick();
        check("xport_after_a", q_b1, 16'h5555);
        cs_b1 = 0;

        // Read-first same-port RDW
        cs_a1 = 1; wren_a1 = 1; addr_a1 = 4'd5; data_a1 = 16'h0011; be_a1 = 2'b11;
        tick();
        data_a1 = 16'h0022;
        tick();
        wren_a1 = 0;
        tick();
        check("rdw1_old", q_a1, 16'h0011);
        tick();
        check("rdw1_new", q_a1, 16'h0022);

        // Latency 2 and hold with cs low
        wren_a1 = 1; addr_a1 = 4'd2; data_a1 = 16'h005C;
        tick();
        wren_a1 = 0;
        tick();
        check("lat_not_yet", q_a1, 16'h0000);
        cs_a1 = 0;
        tick();
        check("lat_two", q_a1, 16'h005C);
        tick();
        check("hold_1", q_a1, 16'h005C);
        tick();
        check("hold_2", q_a1, 16'h005C);

        // Reset mid-clear: interrupt at cycle 9, then a full 16-cycle restart
        cs_a0 = 1; wren_a0 = 0; addr_a0 = 4'd12;
        reset = 1;
        tick();
        reset = 0;
        for (int i = 0; i < 9; i++) tick();
        check("clear_q_hold0", {8'h00, q_a0}, 16'h0000);
        cs_a0 = 0;
        reset = 1;
        tick();
        reset = 0;
        check("busy_restart", {15'b0, busy0}, 16'h0001);
        n = 0;
        while (busy0 && n < 40) begin
            n++;
            tick();
        end
        check("busy_restart_cyc", 16'(n), 16'd16);

        // Memory re-cleared by the restarted sequence
        cs_a0 = 1; addr_a0 = 4'd5;
        cs_b1 = 1; addr_b1 = 4'd7;
        tick();
        check("reclear_rd0", {8'h00, q_a0}, 16'h00A5);
        tick();
        check("reclear_rd1", q_b1, 16'h0000);
        cs_a0 = 0; cs_b1 = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
